// File: rtl/accum40_seq_ctrl_pkg.sv
// Shared types and widths for the 40-bit sequenced accumulator.
package accum40_seq_ctrl_pkg;

    localparam int ACC_W = 40;
    localparam int OP_W  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/accum40_seq_ctrl_adder.sv
// 40-bit plus zero-extended 24-bit adder; bit 40 of the result is the carry-out.
module customAdder40_16
    import accum40_seq_ctrl_pkg::*;
(
    input  logic [ACC_W-1:0] i_a,
    input  logic [OP_W-1:0]  i_b,
    output logic [ACC_W:0]   o_sum
);

    assign o_sum = {1'b0, i_a} + {{(ACC_W - OP_W + 1){1'b0}}, i_b};

endmodule

// File: rtl/accum40_seq_ctrl.sv
// Run controller: loads an operand count on start, accumulates that many
// operands into a wrapping 40-bit register with a sticky carry flag, then pulses done.
module accum40_seq_ctrl
    import accum40_seq_ctrl_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_data,
    output logic [ACC_W-1:0] acc,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output state_t           o_dbg_state
);

    state_t             r_state;
    state_t             w_next;
    logic [LEN_W-1:0]   r_remaining;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [ACC_W:0]     w_sum;
    logic               w_xfer;

    customAdder40_16 u_add (
        .i_a   (r_acc),
        .i_b   (in_data),
        .o_sum (w_sum)
    );

    // Handshake: an operand moves on any rising edge where in_valid && in_ready;
    // in_ready is a pure function of state, so the source may drive in_valid
    // from in_ready without a combinational loop, and may idle for any length.
    assign w_xfer = in_valid && in_ready;

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && (r_remaining == LEN_W'(1))) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && start) begin
                r_acc       <= '0;
                r_ovf       <= 1'b0;
                r_remaining <= len;
            end else if (w_xfer) begin
                r_acc       <= w_sum[ACC_W-1:0];
                r_ovf       <= r_ovf | w_sum[ACC_W];
                r_remaining <= r_remaining - LEN_W'(1);
            end
        end
    end

    assign acc         = r_acc;
    assign overflow    = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_accum40_seq_ctrl.sv
// Directed and randomized runs of accum40_seq_ctrl checked against a run-sum model.
module tb_accum40_seq_ctrl;
    import accum40_seq_ctrl_pkg::*;

    localparam int LEN_W = 17;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [23:0]      in_data;
    logic [39:0]      acc;
    logic             overflow;
    logic             busy;
    logic             done;
    state_t           dbg_state;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [23:0] data_q[$];
    logic [39:0] exp_q[$];
    logic [39:0] last_acc;
    logic        last_ovf;

    accum40_seq_ctrl #(.LEN_W(LEN_W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .acc         (acc),
        .overflow    (overflow),
        .busy        (busy),
        .done        (done),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One run: model keeps the plain arithmetic sum of accepted operands;
    // acc is that sum mod 2^40 and overflow is set iff the sum reached 2^40.
    task automatic run_seq(input int unsigned n, input int mode, input bit poke_start);
        logic [63:0] total;
        int unsigned left;
        int unsigned cyc;
        int unsigned bubbles;
        int unsigned idx;
        bit          v;
        logic [23:0] d;
        total   = 64'd0;
        left    = n;
        bubbles = 0;
        idx     = 0;
        start    = 1'b1;
        len      = n[LEN_W-1:0];
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 24'($urandom);
        tick();
        cyc   = 1;
        start = 1'b0;
        while (left > 0) begin
            chk("accum_ready", {63'd0, in_ready}, 64'd1);
            chk("accum_busy", {63'd0, busy}, 64'd1);
            chk("accum_no_done", {63'd0, done}, 64'd0);
            case (mode)
                0:       v = 1'b1;
                1:       v = ($urandom_range(0, 3) != 0);
                default: v = ((idx % 2) == 0);
            endcase
            d = 24'($urandom);
            if (v && data_q.size() > 0) d = data_q.pop_front();
            in_valid = v;
            in_data  = d;
            if (poke_start) begin
                start = 1'($urandom_range(0, 1));
                len   = LEN_W'($urandom);
            end
            if (v) begin
                total = total + {40'd0, d};
                left--;
            end else begin
                bubbles++;
            end
            idx++;
            tick();
            cyc++;
        end
        exp_q.push_back(total[39:0]);
        last_acc = total[39:0];
        last_ovf = (total[63:40] != 24'd0);
        in_valid = (mode == 2) ? ((idx % 2) == 0) : 1'($urandom_range(0, 1));
        in_data  = 24'($urandom);
        start    = poke_start;
        chk("done_pulse", {63'd0, done}, 64'd1);
        chk("latency", 64'(cyc), 64'(n + 1 + bubbles));
        chk("done_acc", {24'd0, acc}, {24'd0, exp_q.pop_front()});
        chk("done_ovf", {63'd0, overflow}, {63'd0, last_ovf});
        chk("done_ready", {63'd0, in_ready}, 64'd0);
        chk("done_busy", {63'd0, busy}, 64'd1);
        tick();
        idx++;
        start    = 1'b0;
        in_valid = (mode == 2) ? ((idx % 2) == 0) : 1'b0;
        chk("idle_done", {63'd0, done}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_ready", {63'd0, in_ready}, 64'd0);
        chk("idle_acc", {24'd0, acc}, {24'd0, last_acc});
        chk("idle_ovf", {63'd0, overflow}, {63'd0, last_ovf});
    endtask

    task automatic idle_hold(input int unsigned n_cyc);
        for (int i = 0; i < n_cyc; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 24'($urandom);
            tick();
            chk("hold_acc", {24'd0, acc}, {24'd0, last_acc});
            chk("hold_ovf", {63'd0, overflow}, {63'd0, last_ovf});
            chk("hold_ready", {63'd0, in_ready}, 64'd0);
            chk("hold_busy", {63'd0, busy}, 64'd0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;
        last_acc = '0;
        last_ovf = 1'b0;
        tick();
        tick();
        chk("rst_state", 64'(dbg_state), 64'(IDLE));
        chk("rst_acc", {24'd0, acc}, 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        tick();

        data_q = '{24'd5, 24'd7, 24'd9};
        run_seq(3, 0, 1'b0);
        chk("sum_5_7_9", {24'd0, acc}, 64'd21);

        data_q = '{24'hFFFFFF, 24'hFFFFFF};
        run_seq(2, 2, 1'b0);
        chk("sum_two_max", {24'd0, acc}, 64'h1FFFFFE);

        run_seq(0, 0, 1'b0);
        chk("len0_acc", {24'd0, acc}, 64'd0);

        for (int r = 0; r < 8; r++) begin
            run_seq($urandom_range(1, 20), 1, 1'b1);
        end
        idle_hold(3);

        run_seq(300, 1, 1'b0);

        // 65536 x 0xFFFFFF + 0xFFFF lands on 2^40-1; the final +1 wraps to zero.
        data_q.delete();
        for (int i = 0; i < 65536; i++) data_q.push_back(24'hFFFFFF);
        data_q.push_back(24'h00FFFF);
        data_q.push_back(24'h000001);
        run_seq(65538, 0, 1'b0);
        chk("wrap_acc", {24'd0, acc}, 64'd0);
        chk("wrap_ovf", {63'd0, overflow}, 64'd1);

        data_q = '{24'd1};
        run_seq(1, 0, 1'b0);
        chk("b2b_acc", {24'd0, acc}, 64'd1);
        chk("b2b_ovf_clear", {63'd0, overflow}, 64'd0);
        idle_hold(2);

        start = 1'b1;
        len   = LEN_W'(5);
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 24'd100;
        tick();
        tick();
        rst      = 1'b1;
        start    = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        chk("abort_state", 64'(dbg_state), 64'(IDLE));
        chk("abort_acc", {24'd0, acc}, 64'd0);
        chk("abort_ovf", {63'd0, overflow}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_ready", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_done", {63'd0, done}, 64'd0);
            tick();
        end

        rst   = 1'b1;
        start = 1'b1;
        len   = LEN_W'(4);
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_over_start", {63'd0, busy}, 64'd0);

        last_acc = '0;
        last_ovf = 1'b0;
        run_seq($urandom_range(1, 10), 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/accum40_seq_ctrl.md
ACCUM40_SEQ_CTRL -- requirements
Module: accum40_seq_ctrl

Interface
REQ-001 The block SHALL have parameter LEN_W, default 8, giving the width of the operand-count input.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  begin a new accumulation run; sampled only in IDLE.
REQ-005 len  input  LEN_W  number of operands in the run; sampled with start.
REQ-006 in_valid  input  1  in_data holds a valid operand.
REQ-007 in_ready  output  1  block accepts an operand this cycle.
REQ-008 in_data  input  24  unsigned operand, zero-extended to 40 bits before adding.
REQ-009 acc  output  40  accumulator value, registered.
REQ-010 overflow  output  1  sticky carry-out flag for the current run.
REQ-011 busy  output  1  high in ACCUM and DONE.
REQ-012 done  output  1  one-cycle pulse marking the end of a run.

Function
REQ-013 The FSM SHALL have states IDLE, ACCUM and DONE.
REQ-014 IDLE behaviour: in_ready=0, busy=0, done=0; acc and overflow hold their last run's values.
REQ-015 start=1 in IDLE SHALL, on the same edge, clear acc to 0, clear overflow, load remaining<=len, and go to ACCUM (len!=0) or DONE (len==0).
REQ-016 In ACCUM, in_ready SHALL be 1 combinationally from the state only; it SHALL NOT depend on in_valid.
REQ-017 A transfer SHALL occur when in_valid&&in_ready; on that edge acc<=Sum[39:0], where Sum[40:0]=acc+{16'b0,in_data}.
REQ-018 On a transfer, overflow<=overflow|Sum[40] and remaining<=remaining-1.
REQ-019 acc SHALL wrap modulo 2^40; overflow stays set until the next start or reset.
REQ-020 A transfer with remaining==1 SHALL move the FSM to DONE.
REQ-021 ACCUM without a transfer SHALL hold all state; bubbles of in_valid are unbounded.
REQ-022 DONE SHALL last exactly one cycle with done=1, in_ready=0, then return to IDLE.
REQ-023 acc and overflow SHALL be valid in the done cycle and stay stable in IDLE until the next start.
REQ-024 start SHALL be ignored in ACCUM and DONE; a start in the DONE cycle is not queued.
REQ-025 Latency: with in_valid held high, done asserts len+1 cycles after the start edge (len>=1).
REQ-026 len==0 SHALL give done one cycle after start, with acc=0 and overflow=0.
REQ-027 Maximum len (2^LEN_W-1) SHALL complete without remaining-counter wrap.

Reset
REQ-028 rst=1 SHALL force the FSM to IDLE, acc=0, overflow=0, remaining=0, done=0, busy=0, in_ready=0 on the next edge.
REQ-029 rst SHALL take priority over start and over transfers; rst mid-run SHALL abort the run with no done pulse.

Structure
REQ-030 The addition SHALL use one instance of the existing 40-bit plus 24-bit zero-extending adder (customAdder40_16), 41-bit result; no other adder on the acc path.
REQ-031 The shared package SHALL hold the state enum (IDLE/ACCUM/DONE) and constants ACC_W=40, OP_W=24.
REQ-032 The FSM and counter SHALL live in this module; no further sub-modules.

Verification
REQ-033 Reset, then start with len=3 and in_data 5,7,9 (in_valid high) -> acc=21, overflow=0, done 4 cycles after the start edge.
REQ-034 len=2, operands 24'hFFFFFF with in_valid toggling 1,0,1,0,1 -> only two transfers, acc=40'h1FFFFFE, done after the second transfer.
REQ-035 Preload via runs to acc near 2^40: check the wrap case acc=40'hFFFFFFFFFF + 1 -> acc=0, overflow=1 held through DONE and IDLE.
REQ-036 len=0 -> done one cycle after start, acc=0, in_ready never high.
REQ-037 rst asserted after 2 of 5 transfers -> next cycle IDLE, acc=0, no done; start pulsed during ACCUM/DONE -> ignored.
REQ-038 Back-to-back runs: start in the cycle after DONE, len=1, data=1 -> acc=1, overflow cleared from the previous run.
